// File: rtl/prefetch_fetch_unit.sv
// Prefetching fetch stage: DEPTH-entry queue of 16-bit words, assembles 16/32-bit instrs.
// Optional perf counters (stall_count, redirect_count) when FETCH_PERF_COUNT_EN is defined.
module prefetch_fetch_unit #(
  parameter int ADDR_W = 20,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic              instr_is32,
`ifdef FETCH_PERF_COUNT_EN
  output logic [ADDR_W-1:0] instr_pc,
  output logic [31:0]       stall_count,
  output logic [15:0]       redirect_count
`else
  output logic [ADDR_W-1:0] instr_pc
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]       q [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              inflight;
  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     occ;
  logic [15:0]       head;
  logic [15:0]       next_w;
  logic              head32;
  logic              push;
  logic              pop;
  logic [1:0]        pop_n;

  // Occupancy includes the word still on its way back from memory
  assign occ = count + CW'(inflight);

  // Held off during reset and in a redirect cycle so nothing stale is issued
  assign imem_rd_en = reset & ~redirect & (occ < CW'(DEPTH));
  assign imem_addr  = fetch_pc;

  assign head   = q[rd_ptr];
  assign next_w = q[rd_ptr + PW'(1)];
  assign head32 = head[15];

  // A 32-bit instruction is only shown once both halves are queued
  assign instr_valid = (count != '0) & (~head32 | (count >= CW'(2)));
  assign instr_is32  = instr_valid & head32;
  assign instr = !instr_valid ? 32'h0 :
                 head32 ? {next_w, head} : {16'h0, head};

  // Return data arriving in a redirect cycle belongs to the old stream
  assign push  = inflight & ~redirect;
  assign pop   = instr_valid & instr_ready & ~redirect;
  assign pop_n = !pop ? 2'd0 : (head32 ? 2'd2 : 2'd1);

  // Pointers, occupancy, fetch and decode PCs; redirect flushes everything
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
      fetch_pc <= RESET_PC;
      instr_pc <= RESET_PC;
    end else if (redirect) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
      fetch_pc <= redirect_pc;
      instr_pc <= redirect_pc;
    end else begin
      inflight <= imem_rd_en;
      if (imem_rd_en) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr   <= rd_ptr + PW'(pop_n);
      count    <= count + CW'(push) - CW'(pop_n);
      instr_pc <= instr_pc + ADDR_W'(pop_n);
    end
  end

  // Queue storage written at the tail by returning read data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else if (push) begin
      q[wr_ptr] <= imem_data;
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  // Stall cycles wrap; redirects saturate
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (!instr_valid) begin
        stall_count <= stall_count + 32'd1;
      end
      if (redirect && redirect_count != 16'hFFFF) begin
        redirect_count <= redirect_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Scoreboard bench for prefetch_fetch_unit: random ready/redirect/reset,
// instruction stream predicted from memory contents and the PC rules.
module tb_prefetch_fetch_unit;

  localparam int AW = 20;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RPC = '0;

  logic          clock = 1'b0;
  logic          reset;
  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_data;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic          instr_is32;
  logic [AW-1:0] instr_pc;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0]   stall_count;
  logic [15:0]   redirect_count;
`endif

  prefetch_fetch_unit #(
    .ADDR_W(AW),
    .DEPTH(DEPTH),
    .RESET_PC(RPC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .imem_rd_en(imem_rd_en),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_is32(instr_is32),
    .instr_pc(instr_pc)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .stall_count(stall_count),
    .redirect_count(redirect_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0]   instr;
    logic          is32;
    logic [AW-1:0] pc;
  } exp_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] mem [1024];
  int ev_id = 0;
  logic [AW-1:0] ev_pc = '0;
  int ev_lat = 0;
  int rd_since_ev = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mw(logic [AW-1:0] a);
    return mem[a[9:0]];
  endfunction

  function automatic exp_t model_next(inout logic [AW-1:0] pc);
    exp_t e;
    logic [15:0] w;
    logic [15:0] w2;
    w = mw(pc);
    w2 = mw(pc + AW'(1));
    e.pc = pc;
    e.is32 = w[15];
    e.instr = w[15] ? {w2, w} : {16'h0, w};
    pc = pc + (w[15] ? AW'(2) : AW'(1));
    return e;
  endfunction

  // Instruction memory with 1-cycle read latency; also checks the fetch addresses
  initial begin
    logic req;
    logic [AW-1:0] a;
    logic [AW-1:0] ea;
    int seen;
    seen = 0;
    ea = RPC;
    imem_data = 16'h0;
    forever begin
      @(negedge clock);
      if (ev_id != seen) begin
        seen = ev_id;
        ea = ev_pc;
        rd_since_ev = 0;
      end
      req = imem_rd_en;
      a = imem_addr;
      if (!reset || redirect) begin
        chk("rd_en_idle", imem_rd_en, 0);
      end else if (imem_rd_en) begin
        chk("fetch_addr", imem_addr, ea);
        ea = ea + AW'(1);
        rd_since_ev++;
      end
      @(posedge clock);
      #1;
      imem_data = req ? mw(a) : 16'($urandom);
    end
  end

  // Monitor: scoreboard pop, hold stability, restart latency, perf counters
  initial begin
    exp_t q[$];
    exp_t e;
    logic [AW-1:0] mpc;
    logic [15:0] fw;
    int seen;
    bit armed;
    int cyc;
    int lat;
    bit hold;
    logic [31:0] hi;
    logic hs;
    logic [AW-1:0] hp;
    int stalls;
    int redirs;
    seen = 0;
    armed = 0;
    cyc = 0;
    lat = 0;
    hold = 0;
    stalls = 0;
    redirs = 0;
    mpc = RPC;
    forever begin
      @(negedge clock);
      if (!reset) begin
        q.delete();
        armed = 0;
        hold = 0;
        stalls = 0;
        redirs = 0;
        continue;
      end
`ifdef FETCH_PERF_COUNT_EN
      chk("stall_count", stall_count, 32'(stalls));
      chk("redirect_count", redirect_count, 16'(redirs));
`endif
      if (!instr_valid) stalls++;
      if (redirect && redirs < 65535) redirs++;
      if (hold) begin
        chk("hold_valid", instr_valid, 1);
        chk("hold_instr", instr, hi);
        chk("hold_is32", instr_is32, hs);
        chk("hold_pc", instr_pc, hp);
      end
      if (ev_id != seen) begin
        seen = ev_id;
        mpc = ev_pc;
        q.delete();
        repeat (64) q.push_back(model_next(mpc));
        fw = mw(ev_pc);
        lat = ev_lat + int'(fw[15]);
        armed = 1;
        cyc = 1;
      end else if (armed) begin
        if (instr_valid) begin
          chk("first_valid_latency", 64'(cyc), 64'(lat));
          armed = 0;
        end else if (cyc > 8) begin
          chk("first_valid_timeout", instr_valid, 1);
          armed = 0;
        end else begin
          cyc++;
        end
      end
      hold = instr_valid & ~instr_ready & ~redirect;
      hi = instr;
      hs = instr_is32;
      hp = instr_pc;
      if (instr_valid && instr_ready && !redirect) begin
        while (q.size() < 8) q.push_back(model_next(mpc));
        e = q.pop_front();
        chk("instr", instr, e.instr);
        chk("is32", instr_is32, e.is32);
        chk("pc", instr_pc, e.pc);
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_redirect(logic [AW-1:0] pc);
    redirect = 1'b1;
    redirect_pc = pc;
    ev_pc = pc;
    ev_lat = 3;
    ev_id++;
    step();
    redirect = 1'b0;
  endtask

  task automatic release_reset();
    reset = 1'b1;
    ev_pc = RPC;
    ev_lat = 2;
    ev_id++;
  endtask

  // Stimulus: directed scenarios followed by a random phase
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) mem[i] = 16'(i + 1);
    mem[16] = 16'h8123;
    mem[17] = 16'h4567;
    reset = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    step(2);
    chk("rst_rd_en", imem_rd_en, 0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_is32", instr_is32, 0);
    chk("rst_pc", instr_pc, RPC);
    release_reset();
    #1;
    chk("start_rd_en", imem_rd_en, 1);
    chk("start_addr", imem_addr, RPC);
    step(14);
    do_redirect(AW'(16));
    step(6);
    instr_ready = 1'b0;
    do_redirect(20'h00100);
    step(10);
    chk("bp_reads", 64'(rd_since_ev), 64'(DEPTH));
    chk("bp_valid", instr_valid, 1);
    instr_ready = 1'b1;
    step(10);
    do_redirect(20'h00100);
    step(8);
    do_redirect(20'hFFFFF);
    step(8);
    do_redirect(20'h00200);
    do_redirect(20'h00300);
    step(8);
    reset = 1'b0;
    #1;
    chk("midrst_rd_en", imem_rd_en, 0);
    chk("midrst_valid", instr_valid, 0);
    step(3);
    release_reset();
    step(10);
    repeat (3000) begin
      instr_ready = ($urandom % 4) != 0;
      if ($urandom % 400 == 0) begin
        reset = 1'b0;
        step(2);
        release_reset();
        step();
      end else if ($urandom % 25 == 0) begin
        if ($urandom % 4 == 0) do_redirect(20'hFFFFF - AW'($urandom % 3));
        else do_redirect(AW'($urandom));
      end else begin
        step();
      end
    end
    instr_ready = 1'b1;
    step(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
